// File: rtl/tri_pkg.sv
// Shared types and helpers for the triangle feeder.
// Optional bounding-box checking in tri_feed_ctrl is enabled by TRI_FEED_BBOX_CHECK_EN.
package tri_pkg;

  localparam int unsigned GRID_W  = 8;
  localparam int unsigned MAP_W   = 64;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned TRI_W   = 6 * COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  // Field order matches tri_data: x0 occupies the top three bits.
  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
    coord_t x2;
    coord_t y2;
  } tri_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } vtx_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
  } bbox_t;

  typedef enum logic [2:0] {
    StIdle,
    StSend0,
    StSend1,
    StSend2,
    StWaitBusy,
    StCollect,
    StReport
  } feed_state_e;

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous FIFO with full/empty flags; Depth must be a power of two.
module tri_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 18
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tri_feed_ctrl.sv
// Host-side triangle feeder: queues descriptors, drives the 3-cycle vertex protocol and
// builds an 8x8 coverage bitmap per triangle. TRI_FEED_BBOX_CHECK_EN adds a bounding-box check.
module tri_feed_ctrl
  import tri_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [17:0] tri_data,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic        res_valid,
  output logic [6:0]  res_count,
  output logic [63:0] res_map,
  output logic        res_err
);

  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW = $clog2(MAP_W);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);
  localparam logic [6:0]    CountMax   = 7'(MAP_W);

  feed_state_e      state_q, state_d;
  vtx_t             v1_q, v1_d, v2_q, v2_d;
  logic [TW-1:0]    timer_q, timer_d, timer_inc;
  logic             nt_q, nt_d;
  coord_t           xi_q, xi_d, yi_q, yi_d;
  logic             res_valid_q, res_valid_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [MAP_W-1:0] map_q, map_d;
  logic             err_q, err_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [TRI_W-1:0] fifo_rdata;
  tri_t             fifo_head;
  logic             capture_en, pix_dup, pix_oob;
  logic [IdxW-1:0]  pix_idx;

  tri_fifo #(
    .Depth(DEPTH),
    .Width(TRI_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (tri_valid),
    .wdata_i(tri_data),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign fifo_head = tri_t'(fifo_rdata);
  assign tri_ready = !fifo_full;

  assign timer_inc  = timer_q + TW'(1);
  assign pix_idx    = IdxW'(int'(yo) * int'(GRID_W) + int'(xo));
  assign pix_dup    = map_q[pix_idx];
  assign capture_en = po && ((state_q == StSend2) || (state_q == StWaitBusy) ||
                             (state_q == StCollect));

`ifdef TRI_FEED_BBOX_CHECK_EN
  bbox_t bbox_q, bbox_d;

  // Box is latched with the popped descriptor, so it is valid throughout SEND0.
  always_comb begin
    bbox_d = bbox_q;
    if (fifo_pop) begin
      bbox_d.xmin = min3(fifo_head.x0, fifo_head.x1, fifo_head.x2);
      bbox_d.xmax = max3(fifo_head.x0, fifo_head.x1, fifo_head.x2);
      bbox_d.ymin = min3(fifo_head.y0, fifo_head.y1, fifo_head.y2);
      bbox_d.ymax = max3(fifo_head.y0, fifo_head.y1, fifo_head.y2);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bbox_q <= '0;
    else          bbox_q <= bbox_d;
  end

  assign pix_oob = (xo < bbox_q.xmin) || (xo > bbox_q.xmax) ||
                   (yo < bbox_q.ymin) || (yo > bbox_q.ymax);
`else
  assign pix_oob = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    timer_d     = timer_q;
    nt_d        = 1'b0;
    xi_d        = xi_q;
    yi_d        = yi_q;
    res_valid_d = 1'b0;
    cnt_d       = cnt_q;
    map_d       = map_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;

    if (capture_en) begin
      if (pix_dup) begin
        err_d = 1'b1;
      end else begin
        map_d[pix_idx] = 1'b1;
        if (cnt_q != CountMax) cnt_d = cnt_q + 7'd1;
      end
      if (pix_oob) err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !busy) begin
          state_d  = StSend0;
          fifo_pop = 1'b1;
          nt_d     = 1'b1;
          xi_d     = fifo_head.x0;
          yi_d     = fifo_head.y0;
          v1_d     = '{x: fifo_head.x1, y: fifo_head.y1};
          v2_d     = '{x: fifo_head.x2, y: fifo_head.y2};
          cnt_d    = '0;
          map_d    = '0;
          err_d    = 1'b0;
          timer_d  = '0;
        end
      end
      StSend0: begin
        state_d = StSend1;
        xi_d    = v1_q.x;
        yi_d    = v1_q.y;
      end
      StSend1: begin
        state_d = StSend2;
        xi_d    = v2_q.x;
        yi_d    = v2_q.y;
      end
      StSend2: begin
        state_d = StWaitBusy;
        timer_d = '0;
      end
      StWaitBusy: begin
        if (busy) begin
          state_d = StCollect;
          timer_d = '0;
        end else if (timer_inc == TimeoutVal) begin
          state_d     = StReport;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StCollect: begin
        // Any pixel arriving with busy's fall is already folded in above.
        if (!busy) begin
          state_d     = StReport;
          res_valid_d = 1'b1;
          timer_d     = '0;
        end else if (po) begin
          timer_d = '0;
        end else if (timer_inc == TimeoutVal) begin
          state_d     = StReport;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      v1_q        <= '0;
      v2_q        <= '0;
      timer_q     <= '0;
      nt_q        <= 1'b0;
      xi_q        <= '0;
      yi_q        <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      map_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      timer_q     <= timer_d;
      nt_q        <= nt_d;
      xi_q        <= xi_d;
      yi_q        <= yi_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      map_q       <= map_d;
      err_q       <= err_d;
    end
  end

  assign nt        = nt_q;
  assign xi        = xi_q;
  assign yi        = yi_q;
  assign res_valid = res_valid_q;
  assign res_count = cnt_q;
  assign res_map   = map_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_tri_feed_ctrl.sv
// Randomised bench for tri_feed_ctrl: the bench plays host and rasterizer and predicts
// each result record from a set-based coverage model.
module tb_tri_feed_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [17:0] tri_data = '0;
  logic        nt;
  logic [2:0]  xi, yi;
  logic        busy = 1'b0;
  logic        po = 1'b0;
  logic [2:0]  xo = '0, yo = '0;
  logic        res_valid;
  logic [6:0]  res_count;
  logic [63:0] res_map;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  int          px_x[$];
  int          px_y[$];

  always #5 clk = ~clk;

  tri_feed_ctrl #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tri_valid(tri_valid),
    .tri_ready(tri_ready),
    .tri_data (tri_data),
    .nt       (nt),
    .xi       (xi),
    .yi       (yi),
    .busy     (busy),
    .po       (po),
    .xo       (xo),
    .yo       (yo),
    .res_valid(res_valid),
    .res_count(res_count),
    .res_map  (res_map),
    .res_err  (res_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(int x0, int y0, int x1, int y1, int x2, int y2);
    return {3'(x0), 3'(y0), 3'(x1), 3'(y1), 3'(x2), 3'(y2)};
  endfunction

  // k = 0..5 selects x0,y0,x1,y1,x2,y2
  function automatic int fld(input logic [17:0] t, input int k);
    return int'(t[17-3*k -: 3]);
  endfunction

  function automatic bit in_box(input logic [17:0] t, input int x, input int y);
    int xmin, xmax, ymin, ymax;
    xmin = fld(t, 0); xmax = fld(t, 0); ymin = fld(t, 1); ymax = fld(t, 1);
    for (int k = 1; k < 3; k++) begin
      if (fld(t, 2*k) < xmin) xmin = fld(t, 2*k);
      if (fld(t, 2*k) > xmax) xmax = fld(t, 2*k);
      if (fld(t, 2*k+1) < ymin) ymin = fld(t, 2*k+1);
      if (fld(t, 2*k+1) > ymax) ymax = fld(t, 2*k+1);
    end
    return (x >= xmin) && (x <= xmax) && (y >= ymin) && (y <= ymax);
  endfunction

  task automatic push(input logic [17:0] t);
    int n = 0;
    @(negedge clk);
    while (!tri_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", tri_ready, 1);
    tri_valid = 1'b1;
    tri_data  = t;
    exp_q.push_back(t);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  // Waits for nt, then checks the three vertex cycles; returns on the SEND2 cycle.
  task automatic serve_send(output int lat, output logic [17:0] t);
    lat = 0;
    t   = '0;
    while (nt !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("nt_seen", nt, 1);
    check("model_has_tri", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    t = exp_q.pop_front();
    check("v0", {nt, xi, yi}, {1'b1, t[17:15], t[14:12]});
    @(negedge clk);
    check("v1", {nt, xi, yi}, {1'b0, t[11:9], t[8:6]});
    @(negedge clk);
    check("v2", {nt, xi, yi}, {1'b0, t[5:3], t[2:0]});
  endtask

  // Plays the rasterizer for px_x/px_y and checks the resulting record.
  task automatic collect(input logic [17:0] t);
    logic [63:0] m = '0;
    int          cnt = 0;
    bit          err = 1'b0;
    int          w = 0;
    int          n;
    foreach (px_x[i]) begin
      int b = px_y[i] * 8 + px_x[i];
      if (m[b]) err = 1'b1;
      else begin
        m[b] = 1'b1;
        cnt++;
      end
`ifdef TRI_FEED_BBOX_CHECK_EN
      if (!in_box(t, px_x[i], px_y[i])) err = 1'b1;
`endif
    end
    n = px_x.size();
    busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (n == 0) begin
      busy = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        po = 1'b0;
        @(negedge clk);
      end
      po = 1'b1;
      xo = 3'(px_x[i]);
      yo = 3'(px_y[i]);
      if (i == n - 1) busy = 1'b0;
      @(negedge clk);
    end
    po = 1'b0;
    while (res_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("res_valid", res_valid, 1);
    check("res_count", res_count, 64'(cnt));
    check("res_map", res_map, m);
    check("res_err", res_err, 64'(err));
    @(negedge clk);
    check("res_pulse", res_valid, 0);
  endtask

  task automatic gen_pixels(input logic [17:0] t);
    int n, r, k, x, y;
    px_x.delete();
    px_y.delete();
    n = $urandom_range(1, 8);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0 && i > 0) begin
        k = $urandom_range(0, i - 1);
        x = px_x[k];
        y = px_y[k];
      end else if (r < 3) begin
        x = $urandom_range(0, 7);
        y = $urandom_range(0, 7);
      end else begin
        do begin
          x = $urandom_range(0, 7);
          y = $urandom_range(0, 7);
        end while (!in_box(t, x, y));
      end
      px_x.push_back(x);
      px_y.push_back(y);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n, nt_cnt;
    logic [17:0] t, ta;

    repeat (3) @(negedge clk);
    check("rst_outs", {nt, xi, yi, res_valid, res_count, res_err}, 0);
    check("rst_map", res_map, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", tri_ready, 1);

    // Reference triangle with its full pixel set.
    push(mk(1, 0, 3, 2, 1, 4));
    serve_send(lat, t);
    check("latency", lat, 1);
    px_x = '{1, 1, 2, 1, 2, 3, 1, 2, 1};
    px_y = '{0, 1, 1, 2, 2, 2, 3, 3, 4};
    collect(t);

    // Duplicate pixel.
    push(mk(1, 0, 3, 2, 1, 4));
    serve_send(lat, t);
    px_x = '{1, 1, 2, 1, 2, 2, 3, 1, 2};
    px_y = '{0, 1, 1, 2, 2, 2, 2, 3, 3};
    collect(t);

    // busy never asserted.
    push(mk(2, 2, 5, 2, 3, 6));
    serve_send(lat, t);
    @(negedge clk);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_count", res_count, 0);
    check("timeout_map", res_map, 0);
    check("timeout_err", res_err, 1);

    // Pixel far outside the triangle's box.
    push(mk(0, 0, 2, 1, 0, 2));
    serve_send(lat, t);
    px_x = '{0, 7};
    px_y = '{0, 7};
    collect(t);
    check("bit63", res_map[63], 1);

    // Queue fill: one issued, four queued, fifth refused.
    push(mk(4, 4, 6, 4, 5, 7));
    serve_send(lat, ta);
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("q_ready", tri_ready, 1);
      t = 18'($urandom());
      tri_valid = 1'b1;
      tri_data  = t;
      exp_q.push_back(t);
    end
    @(negedge clk);
    tri_valid = 1'b0;
    check("q_full", tri_ready, 0);
    tri_valid = 1'b1;
    tri_data  = 18'($urandom());
    @(negedge clk);
    tri_valid = 1'b0;
    check("q_still_full", tri_ready, 0);
    gen_pixels(ta);
    collect(ta);
    for (int i = 0; i < 4; i++) begin
      serve_send(lat, t);
      gen_pixels(t);
      collect(t);
    end
    check("q_drained", exp_q.size(), 0);

    // Random triangles and pixel streams.
    for (int i = 0; i < 10; i++) begin
      push(18'($urandom()));
      serve_send(lat, t);
      gen_pixels(t);
      collect(t);
    end

    // Reset in COLLECT with two triangles queued.
    push(mk(1, 1, 6, 1, 3, 5));
    serve_send(lat, t);
    busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tri_valid = 1'b1;
      tri_data  = 18'($urandom());
    end
    @(negedge clk);
    tri_valid = 1'b0;
    po = 1'b1;
    xo = 3'd3;
    yo = 3'd2;
    @(negedge clk);
    po = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", {nt, xi, yi, res_valid, res_count, res_err}, 0);
    check("mid_rst_map", res_map, 0);
    check("mid_rst_ready", tri_ready, 1);
    busy = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    nt_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (nt === 1'b1) nt_cnt++;
    end
    check("no_nt_after_rst", nt_cnt, 0);
    push(mk(2, 3, 4, 3, 3, 5));
    serve_send(lat, t);
    gen_pixels(t);
    collect(t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
